// File: rtl/uart_ext_pkg.sv
// rtl/uart_ext_pkg.sv - shared register map, ctrl fields, state enums and frame helpers for uart_core_ext
package uart_ext_pkg;

    localparam logic [4:0] REG_STATUS  = 5'd0;
    localparam logic [4:0] REG_DVSR    = 5'd1;
    localparam logic [4:0] REG_TX_DATA = 5'd2;
    localparam logic [4:0] REG_RX_POP  = 5'd3;
    localparam logic [4:0] REG_CTRL    = 5'd4;
    localparam logic [4:0] REG_ERR_CLR = 5'd5;
    localparam logic [4:0] REG_LEVEL   = 5'd6;

    localparam int CTRL_WLEN_LSB = 0;
    localparam int CTRL_STOP2    = 2;
    localparam int CTRL_PAR_LSB  = 3;
    localparam int CTRL_RX_IE    = 5;
    localparam int CTRL_TX_IE    = 6;
    localparam int CTRL_ERR_IE   = 7;
    localparam int CTRL_LOOPBACK = 8;

    localparam int ERR_PARITY  = 0;
    localparam int ERR_FRAME   = 1;
    localparam int ERR_OVERRUN = 2;

    typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_t;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // Per-frame snapshot of the line format
    typedef struct packed {
        logic [1:0] wlen;
        logic       stop2;
        parity_t    parity;
    } frame_cfg_t;

    localparam frame_cfg_t FRAME_CFG_RESET = '{wlen: 2'd3, stop2: 1'b0, parity: PAR_NONE};

    // ctrl[4:0] -> frame format; the parity code 11 is treated as none
    function automatic frame_cfg_t decode_cfg(input logic [4:0] f);
        frame_cfg_t c;
        c.wlen  = f[CTRL_WLEN_LSB +: 2];
        c.stop2 = f[CTRL_STOP2];
        case (f[CTRL_PAR_LSB +: 2])
            2'b01:   c.parity = PAR_EVEN;
            2'b10:   c.parity = PAR_ODD;
            default: c.parity = PAR_NONE;
        endcase
        return c;
    endfunction

    // Mask of the valid data bits for word length 5+wlen
    function automatic logic [7:0] word_mask(input logic [1:0] wlen);
        return 8'hFF >> (2'd3 - wlen);
    endfunction

    // Parity bit to put on the line for the valid data bits
    function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] wlen, input parity_t p);
        logic ones;
        ones = ^(d & word_mask(wlen));
        return (p == PAR_ODD) ? ~ones : ones;
    endfunction

endpackage

// File: rtl/uart_ext_fifo.sv
// rtl/uart_ext_fifo.sv - synchronous FIFO with occupancy count, used for both TX and RX queues
module uart_ext_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   count
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    // A pop frees the slot a same-cycle push needs, so push+pop is accepted at full and at empty
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & (~empty | push);

    assign empty   = (count == '0);
    assign full    = (count == (ADDR_WIDTH+1)'(DEPTH));
    assign rd_data = mem[rd_ptr];

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks net occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (ADDR_WIDTH+1)'(1);
                2'b01:   count <= count - (ADDR_WIDTH+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_core_ext.sv
// rtl/uart_core_ext.sv - MMIO UART slot core with runtime frame format, errors, levels, irq; optional UART_LOOPBACK_EN
module uart_core_ext
    import uart_ext_pkg::*;
#(
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int DVSR_WIDTH      = 11,
    parameter int OVERSAMPLE      = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  reg_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        tx,
    input  logic        rx,
    output logic        irq
);
    localparam int            TW     = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam int            CW     = FIFO_DEPTH_LOG2 + 1;

    logic                  wr_en;
    logic [DVSR_WIDTH-1:0] dvsr_q;
    logic [7:0]            ctrl_q;
    logic                  lb_bit;
    logic [2:0]            err_q;
    logic [2:0]            err_set;
    logic [2:0]            err_clr;
    logic [DVSR_WIDTH-1:0] baud_cnt;
    logic                  tick;

    logic                  tx_push, tx_pop, tx_empty, tx_full;
    logic [7:0]            tx_fifo_data;
    logic [CW-1:0]         tx_count;
    logic                  rx_push, rx_pop, rx_empty, rx_full;
    logic [7:0]            rx_fifo_data;
    logic [CW-1:0]         rx_count;

    tx_state_t             tx_state, tx_state_n;
    logic [TW-1:0]         tx_tcnt;
    logic [2:0]            tx_bit;
    logic [7:0]            tx_shift;
    logic                  tx_par;
    logic                  tx_stop_idx;
    frame_cfg_t            tx_cfg;
    logic                  tx_bit_end;
    logic                  tx_serial;
    logic                  tx_line_q;

    rx_state_t             rx_state, rx_state_n;
    logic [TW-1:0]         rx_tcnt;
    logic [2:0]            rx_bit;
    logic [7:0]            rx_shift;
    logic                  rx_par_err;
    frame_cfg_t            rx_cfg;
    logic                  rx_meta, rx_sync, rx_in;
    logic                  rx_sample;

    logic                  unused_ok;

    assign unused_ok = &{1'b0, read, wr_data[31:DVSR_WIDTH]};
    assign wr_en     = cs & write;
    assign tx_push   = wr_en & (reg_addr == REG_TX_DATA);
    assign rx_pop    = wr_en & (reg_addr == REG_RX_POP);
    assign err_clr   = (wr_en && reg_addr == REG_ERR_CLR) ? wr_data[2:0] : 3'b000;

`ifdef UART_LOOPBACK_EN
    logic lb_q;
    assign lb_bit = lb_q;
    assign rx_in  = lb_q ? tx_line_q : rx_sync;
    assign tx     = lb_q ? 1'b1 : tx_line_q;

    // Loopback enable lives in ctrl[8]
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                          lb_q <= 1'b0;
        else if (wr_en && reg_addr == REG_CTRL) lb_q <= wr_data[CTRL_LOOPBACK];
    end
`else
    assign lb_bit = 1'b0;
    assign rx_in  = rx_sync;
    assign tx     = tx_line_q;
`endif

    uart_ext_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(FIFO_DEPTH_LOG2)) u_tx_fifo (
        .clk(clk), .reset_n(reset_n), .push(tx_push), .pop(tx_pop), .wr_data(wr_data[7:0]),
        .rd_data(tx_fifo_data), .empty(tx_empty), .full(tx_full), .count(tx_count)
    );

    uart_ext_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(FIFO_DEPTH_LOG2)) u_rx_fifo (
        .clk(clk), .reset_n(reset_n), .push(rx_push), .pop(rx_pop), .wr_data(rx_shift),
        .rd_data(rx_fifo_data), .empty(rx_empty), .full(rx_full), .count(rx_count)
    );

    // Writable registers and sticky error flags (a same-cycle set beats the clear)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dvsr_q <= '0;
            ctrl_q <= 8'h03;
            err_q  <= 3'b000;
        end else begin
            if (wr_en && reg_addr == REG_DVSR) dvsr_q <= wr_data[DVSR_WIDTH-1:0];
            if (wr_en && reg_addr == REG_CTRL) ctrl_q <= wr_data[7:0];
            err_q <= (err_q & ~err_clr) | err_set;
        end
    end

    // Baud counter runs 0..dvsr and ticks on the terminal value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      baud_cnt <= '0;
        else if (tick)     baud_cnt <= '0;
        else               baud_cnt <= baud_cnt + DVSR_WIDTH'(1);
    end
    assign tick = (baud_cnt >= dvsr_q);

    // ---------------- TX ----------------
    assign tx_bit_end = tick & (tx_tcnt == T_LAST);

    // TX state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tx_state <= TX_IDLE;
        else          tx_state <= tx_state_n;
    end

    // TX next state; a queued byte follows the last stop bit with no idle gap
    always_comb begin
        tx_state_n = tx_state;
        case (tx_state)
            TX_IDLE:   if (tick && !tx_empty) tx_state_n = TX_START;
            TX_START:  if (tx_bit_end) tx_state_n = TX_DATA;
            TX_DATA:   if (tx_bit_end && tx_bit == (3'd4 + {1'b0, tx_cfg.wlen}))
                           tx_state_n = (tx_cfg.parity == PAR_NONE) ? TX_STOP : TX_PARITY;
            TX_PARITY: if (tx_bit_end) tx_state_n = TX_STOP;
            TX_STOP:   if (tx_bit_end && (!tx_cfg.stop2 || tx_stop_idx))
                           tx_state_n = tx_empty ? TX_IDLE : TX_START;
            default:   tx_state_n = TX_IDLE;
        endcase
    end

    // TX outputs: line level per state, FIFO pop on every entry into START
    always_comb begin
        tx_serial = 1'b1;
        case (tx_state)
            TX_START:  tx_serial = 1'b0;
            TX_DATA:   tx_serial = tx_shift[0];
            TX_PARITY: tx_serial = tx_par;
            default:   tx_serial = 1'b1;
        endcase
        tx_pop = (tx_state_n == TX_START) && (tx_state != TX_START);
    end

    // TX datapath: load byte and format at frame start, then shift per bit period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_tcnt     <= '0;
            tx_bit      <= '0;
            tx_shift    <= '0;
            tx_par      <= 1'b0;
            tx_stop_idx <= 1'b0;
            tx_cfg      <= FRAME_CFG_RESET;
            tx_line_q   <= 1'b1;
        end else begin
            tx_line_q <= tx_serial;
            if (tx_pop) begin
                tx_shift    <= tx_fifo_data;
                tx_cfg      <= decode_cfg(ctrl_q[4:0]);
                tx_par      <= parity_bit(tx_fifo_data, decode_cfg(ctrl_q[4:0]).wlen,
                                          decode_cfg(ctrl_q[4:0]).parity);
                tx_tcnt     <= '0;
                tx_bit      <= '0;
                tx_stop_idx <= 1'b0;
            end else if (tick) begin
                if (tx_tcnt == T_LAST) begin
                    tx_tcnt <= '0;
                    if (tx_state == TX_DATA) begin
                        tx_shift <= tx_shift >> 1;
                        tx_bit   <= tx_bit + 3'd1;
                    end
                    if (tx_state == TX_STOP) tx_stop_idx <= 1'b1;
                end else begin
                    tx_tcnt <= tx_tcnt + TW'(1);
                end
            end
        end
    end

    // ---------------- RX ----------------
    // Two-flop synchroniser for the asynchronous rx pin, idles high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Start bit is checked at its middle; every later bit one full period after
    assign rx_sample = tick & ((rx_state == RX_START) ? (rx_tcnt == T_HALF) : (rx_tcnt == T_LAST));

    // RX state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rx_state <= RX_IDLE;
        else          rx_state <= rx_state_n;
    end

    // RX next state; a start bit that is high at mid-point is a glitch
    always_comb begin
        rx_state_n = rx_state;
        case (rx_state)
            RX_IDLE:   if (tick && !rx_in) rx_state_n = RX_START;
            RX_START:  if (rx_sample) rx_state_n = rx_in ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_sample && rx_bit == (3'd4 + {1'b0, rx_cfg.wlen}))
                           rx_state_n = (rx_cfg.parity == PAR_NONE) ? RX_STOP : RX_PARITY;
            RX_PARITY: if (rx_sample) rx_state_n = RX_STOP;
            RX_STOP:   if (rx_sample) rx_state_n = RX_IDLE;
            default:   rx_state_n = RX_IDLE;
        endcase
    end

    // RX outputs: push at the first stop sample and flag errors there
    always_comb begin
        rx_push                = (rx_state == RX_STOP) && rx_sample;
        err_set                = 3'b000;
        err_set[ERR_PARITY]    = rx_push & rx_par_err;
        err_set[ERR_FRAME]     = rx_push & ~rx_in;
        err_set[ERR_OVERRUN]   = rx_push & rx_full & ~rx_pop;
    end

    // RX datapath: format latched on start detect, bits assembled LSB first
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_tcnt    <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_err <= 1'b0;
            rx_cfg     <= FRAME_CFG_RESET;
        end else if (rx_state == RX_IDLE) begin
            rx_tcnt    <= '0;
            rx_bit     <= '0;
            rx_shift   <= '0;
            rx_par_err <= 1'b0;
            if (tick && !rx_in) rx_cfg <= decode_cfg(ctrl_q[4:0]);
        end else if (tick) begin
            if (rx_sample) begin
                rx_tcnt <= '0;
                if (rx_state == RX_DATA) begin
                    rx_shift[rx_bit] <= rx_in;
                    rx_bit           <= rx_bit + 3'd1;
                end
                if (rx_state == RX_PARITY)
                    rx_par_err <= (rx_in != parity_bit(rx_shift, rx_cfg.wlen, rx_cfg.parity));
            end else begin
                rx_tcnt <= rx_tcnt + TW'(1);
            end
        end
    end

    // Level interrupt, one clock behind its sources
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) irq <= 1'b0;
        else          irq <= (ctrl_q[CTRL_RX_IE] & ~rx_empty) | (ctrl_q[CTRL_TX_IE] & tx_empty) |
                             (ctrl_q[CTRL_ERR_IE] & |err_q);
    end

    // Combinational read mux; reads have no side effects
    always_comb begin
        rd_data = '0;
        case (reg_addr)
            REG_STATUS: rd_data[13:0] = {err_q, tx_empty, tx_full, rx_empty,
                                         rx_empty ? 8'h00 : rx_fifo_data};
            REG_DVSR:   rd_data[DVSR_WIDTH-1:0] = dvsr_q;
            REG_CTRL: begin
                rd_data[7:0]          = ctrl_q;
                rd_data[CTRL_LOOPBACK] = lb_bit;
            end
            REG_LEVEL: begin
                rd_data[FIFO_DEPTH_LOG2:0]       = rx_count;
                rd_data[16+FIFO_DEPTH_LOG2:16]   = tx_count;
            end
            default:    rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_core_ext.sv
// tb/tb_uart_core_ext.sv - scoreboard bench for uart_core_ext
module tb_uart_core_ext;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  reg_addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        tx;
    logic        rx;
    logic        irq;
    logic        loop_en = 1'b0;
    logic        rx_drv = 1'b1;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];

    assign rx = loop_en ? tx : rx_drv;

    always #5 clk = ~clk;

    uart_core_ext dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .read(read), .write(write),
        .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data),
        .tx(tx), .rx(rx), .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; write = 1'b1; reg_addr = a; wr_data = d;
        @(negedge clk);
        cs = 1'b0; write = 1'b0; wr_data = '0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(negedge clk);
        cs = 1'b1; read = 1'b1; reg_addr = a;
        #1 d = rd_data;
        cs = 1'b0; read = 1'b0;
    endtask

    // Expected line levels for one frame, sampled at start, middle and end of each bit
    task automatic check_tx_frame(input string tag, input logic [7:0] data, input int nbits,
                                  input int par, input int nstop, input int bitlen);
        logic       bits[$];
        logic [7:0] m;
        logic       p;
        int         n;
        m = 8'hFF >> (8 - nbits);
        bits.push_back(1'b0);
        for (int i = 0; i < nbits; i++) bits.push_back(data[i]);
        if (par != 0) begin
            p = ^(data & m);
            if (par == 2) p = ~p;
            bits.push_back(p);
        end
        for (int i = 0; i < nstop; i++) bits.push_back(1'b1);
        n = 0;
        while (tx !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check({tag, "_start_timeout"}, 32'(tx), 32'd0);
            return;
        end
        for (int b = 0; b < bits.size(); b++) begin
            for (int o = 0; o < bitlen; o++) begin
                if (o == 0 || o == bitlen / 2 || o == bitlen - 1)
                    check($sformatf("%s_bit%0d_off%0d", tag, b, o), 32'(tx), 32'(bits[b]));
                @(negedge clk);
            end
        end
    endtask

    task automatic wait_rx(input string tag, input int n);
        logic [31:0] d;
        int          t;
        t = 0;
        do begin
            bus_read(5'd6, d);
            t++;
        end while (d[3:0] < n && t < 4000);
        check({tag, "_rx_wait"}, 32'(t < 4000), 32'd1);
    endtask

    // Pop every received byte and compare against the scoreboard
    task automatic drain_rx(input string tag);
        logic [31:0] d;
        int          cnt;
        bus_read(5'd6, d);
        cnt = int'(d[3:0]);
        check({tag, "_rx_count"}, 32'(cnt), 32'(exp_q.size()));
        while (cnt > 0 && exp_q.size() > 0) begin
            bus_read(5'd0, d);
            check({tag, "_rx_empty_flag"}, 32'(d[8]), 32'd0);
            check({tag, "_rx_data"}, d[7:0], exp_q.pop_front());
            bus_write(5'd3, 32'd0);
            cnt--;
        end
        exp_q.delete();
        bus_read(5'd0, d);
        check({tag, "_rx_empty_after"}, 32'(d[8]), 32'd1);
    endtask

    task automatic send_bits(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rx_drv = bits[i];
            repeat (16) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          t;

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("reset_tx", 32'(tx), 32'd1);
        check("reset_irq", 32'(irq), 32'd0);
        bus_read(5'd0, d); check("reset_reg0", d, 32'h0000_0500);
        bus_read(5'd4, d); check("reset_reg4", d, 32'h0000_0003);
        bus_read(5'd6, d); check("reset_reg6", d, 32'h0000_0000);
        bus_read(5'd1, d); check("reset_dvsr", d, 32'h0000_0000);
        bus_read(5'd7, d); check("unmapped_read", d, 32'h0000_0000);

        bus_write(5'd1, 32'hFFFF_F955);
        bus_read(5'd1, d); check("dvsr_rw", d, 32'h0000_0155);
        bus_write(5'd1, 32'd0);

        // 8N1 loopback at dvsr=0
        loop_en = 1'b1;
        bus_write(5'd2, 32'h0000_00A5);
        exp_q.push_back(8'hA5);
        check_tx_frame("tx_a5", 8'hA5, 8, 0, 1, 16);
        wait_rx("a5", 1);
        drain_rx("a5");

        // 7E2
        bus_write(5'd4, 32'h0000_000E);
        bus_write(5'd2, 32'h0000_0055);
        exp_q.push_back(8'h55);
        check_tx_frame("tx_7e2", 8'h55, 7, 1, 2, 16);
        wait_rx("7e2", 1);
        bus_read(5'd0, d); check("7e2_no_err", 32'(d[13:11]), 32'd0);
        drain_rx("7e2");

        // 8N1 at dvsr=1: every bit is 32 clocks
        bus_write(5'd4, 32'h0000_0003);
        bus_write(5'd1, 32'd1);
        bus_write(5'd2, 32'h0000_0081);
        exp_q.push_back(8'h81);
        check_tx_frame("tx_dvsr1", 8'h81, 8, 0, 1, 32);
        wait_rx("dvsr1", 1);
        drain_rx("dvsr1");
        bus_write(5'd1, 32'd0);

        // Overrun: nine frames into an eight-deep RX FIFO
        bus_write(5'd4, 32'h0000_0083);
        for (int i = 0; i < 9; i++) begin
            bus_write(5'd2, 32'(8'h10 + i));
            if (i < 8) exp_q.push_back(8'(8'h10 + i));
        end
        t = 0;
        do begin
            bus_read(5'd0, d);
            t++;
        end while (d[13] !== 1'b1 && t < 4000);
        check("ovr_set", 32'(d[13]), 32'd1);
        bus_read(5'd6, d); check("ovr_rx_count", 32'(d[3:0]), 32'd8);
        check("ovr_irq", 32'(irq), 32'd1);
        bus_write(5'd5, 32'h0000_0004);
        bus_read(5'd0, d); check("ovr_cleared", 32'(d[13]), 32'd0);
        check("ovr_irq_cleared", 32'(irq), 32'd0);
        repeat (40) @(negedge clk);
        drain_rx("ovr");
        bus_write(5'd4, 32'h0000_0003);
        loop_en = 1'b0;
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);

        // Frame error: 0x3C with stop bit 0
        exp_q.push_back(8'h3C);
        send_bits({2'b11, 1'b0, 8'h3C, 1'b0}, 10);
        wait_rx("ferr", 1);
        bus_read(5'd0, d);
        check("ferr_flag", 32'(d[12]), 32'd1);
        check("ferr_no_parity", 32'(d[11]), 32'd0);
        drain_rx("ferr");

        // Parity error: 0x3C with even parity but parity bit 1
        bus_write(5'd5, 32'h0000_0007);
        bus_write(5'd4, 32'h0000_000B);
        exp_q.push_back(8'h3C);
        send_bits({1'b1, 1'b1, 1'b1, 8'h3C, 1'b0}, 11);
        wait_rx("perr", 1);
        bus_read(5'd0, d);
        check("perr_flag", 32'(d[11]), 32'd1);
        check("perr_no_frame", 32'(d[12]), 32'd0);
        drain_rx("perr");

        // Start-bit glitch is rejected; a following good frame still lands
        bus_write(5'd5, 32'h0000_0007);
        bus_write(5'd4, 32'h0000_0003);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
        bus_read(5'd6, d); check("glitch_rx_count", 32'(d[3:0]), 32'd0);
        exp_q.push_back(8'h5A);
        send_bits({2'b11, 1'b1, 8'h5A, 1'b0}, 10);
        wait_rx("post_glitch", 1);
        bus_write(5'd4, 32'h0000_0023);
        @(negedge clk);
        check("rx_ie_irq", 32'(irq), 32'd1);
        bus_write(5'd4, 32'h0000_0003);
        drain_rx("post_glitch");

        // TX-empty interrupt
        @(negedge clk);
        check("irq_before_txie", 32'(irq), 32'd0);
        bus_write(5'd4, 32'h0000_0043);
        @(negedge clk);
        check("tx_ie_irq", 32'(irq), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
